// File: rtl/data_memory.sv
// Main data memory model behind the L1 data cache: 512 x 256-bit lines, one whole-line request at a time.
// Fixed LATENCY cycles from acceptance to end of the one-cycle ack; requests are ignored while one is in flight.
module data_memory #(
   parameter int DEPTH   = 512,
   parameter int WIDTH   = 256,
   parameter int LATENCY = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      addr_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             enable_i,
   input  logic             write_i,
   output logic             ack_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int          IDXW     = $clog2(DEPTH);
   localparam logic [3:0]  CNT_LAST = 4'(LATENCY - 2);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   logic [WIDTH-1:0] memory [DEPTH];

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] dat_q, dat_d;
   logic             wr_q, wr_d;
   logic             mem_we;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         dat_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dat_q   <= dat_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dat_d   = dat_q;
      wr_d    = wr_q;
      unique case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d = BUSY;
               cnt_d   = '0;
               idx_d   = addr_i[5 +: IDXW];
               dat_d   = data_i;
               wr_d    = write_i;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // enable_i is deliberately not sampled here; next acceptance is one edge later
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      ack_o  = (state_q == DONE);
      mem_we = (state_q == DONE) && wr_q;
   end

   // Storage has no reset so preloaded contents survive a reset
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         memory[idx_q] <= dat_q;
      end
   end

   assign data_o = memory[idx_q];

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: table of whole-line requests plus hand-written
// back-to-back, mid-request-change and asynchronous-reset sequences.
module tb_data_memory;

   localparam int LAT = 10;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [31:0]  addr_i = '0;
   logic [255:0] data_i = '0;
   logic         enable_i = 1'b0;
   logic         write_i = 1'b0;
   logic         ack_o;
   logic [255:0] data_o;

   int tests  = 0;
   int failed = 0;

   data_memory #(.DEPTH(512), .WIDTH(256), .LATENCY(LAT)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .enable_i(enable_i),
      .write_i (write_i),
      .ack_o   (ack_o),
      .data_o  (data_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wdat;
      logic [255:0] exp_rd;
      int           idx;
   } vec_t;

   localparam logic [255:0] P0   = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
   localparam logic [255:0] ECFA = {16{16'hECFA}};
   localparam logic [255:0] L16  = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [255:0] W16  = {8{32'hA5A5_5A5A}};
   localparam logic [255:0] L32  = {8{32'h3232_3232}};
   localparam logic [255:0] L40  = {8{32'h4040_4040}};
   localparam logic [255:0] W40  = {8{32'hC0DE_0040}};
   localparam logic [255:0] Q48  = {8{32'h4848_4848}};
   localparam logic [255:0] W48  = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] L511 = {8{32'h0511_0511}};
   localparam logic [255:0] W511 = {8{32'hFEED_F00D}};

   vec_t vecs[9];

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Waits for ack (bounded); returns the number of edges from acceptance (inclusive) to ack visible
   task automatic wait_ack(output int n);
      n = 1;
      while (!ack_o && n < 3 * LAT) begin
         step();
         n++;
      end
   endtask

   // Issues one request from IDLE and checks latency, ack data, ack width and memory effect
   task automatic run_req(input vec_t v, input string nm);
      int n;
      enable_i = 1'b1;
      write_i  = v.wr;
      addr_i   = v.addr;
      data_i   = v.wdat;
      step();
      enable_i = 1'b0;
      wait_ack(n);
      check({nm, " latency"}, 256'(n), 256'(LAT));
      check({nm, " ack data"}, data_o, v.exp_rd);
      step();
      check({nm, " ack width"}, 256'(ack_o), 256'(0));
      check({nm, " mem after"}, dut.memory[v.idx], v.wr ? v.wdat : v.exp_rd);
   endtask

   initial begin
      int n;
      int highs;
      logic exp_ack;

      vecs[0] = '{1'b0, 32'h0000_0000, '0,   P0,   0};
      vecs[1] = '{1'b1, 32'h0000_0400, ECFA, L32,  32};
      vecs[2] = '{1'b0, 32'h0000_041C, '0,   ECFA, 32};
      vecs[3] = '{1'b1, 32'h0000_0200, W16,  L16,  16};
      vecs[4] = '{1'b0, 32'h0000_021F, '0,   W16,  16};
      vecs[5] = '{1'b0, 32'h0000_4000, '0,   P0,   0};
      vecs[6] = '{1'b0, 32'hFFFF_FFE0, '0,   L511, 511};
      vecs[7] = '{1'b1, 32'h0000_3FE0, W511, L511, 511};
      vecs[8] = '{1'b0, 32'h0000_3FFF, '0,   W511, 511};

      #12;
      check("reset ack", 256'(ack_o), 256'(0));
      dut.memory[0]   = P0;
      dut.memory[16]  = L16;
      dut.memory[32]  = L32;
      dut.memory[40]  = L40;
      dut.memory[48]  = Q48;
      dut.memory[511] = L511;
      #5 rst_i = 1'b0;
      step();
      check("idle ack", 256'(ack_o), 256'(0));

      for (int i = 0; i < 9; i++) begin
         run_req(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back reads with enable held high: acks after edges 10, 21, 32
      enable_i = 1'b1;
      write_i  = 1'b0;
      addr_i   = 32'h0;
      for (int k = 1; k <= 45; k++) begin
         step();
         exp_ack = (k == 10) || (k == 21) || (k == 32);
         check($sformatf("b2b ack k=%0d", k), 256'(ack_o), 256'(exp_ack));
         if (k == 32) enable_i = 1'b0;
      end

      // Inputs changed and enable dropped right after acceptance
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_0500;
      data_i   = W40;
      step();
      enable_i = 1'b0;
      write_i  = 1'b0;
      addr_i   = 32'h0;
      data_i   = {8{32'hBAD0_BAD0}};
      wait_ack(n);
      check("midchg latency", 256'(n), 256'(LAT));
      check("midchg ack data", data_o, L40);
      step();
      check("midchg line40", dut.memory[40], W40);
      check("midchg line0", dut.memory[0], P0);
      highs = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (ack_o) highs++;
      end
      check("midchg no new req", 256'(highs), 256'(0));

      // Reset while BUSY on a write
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_0600;
      data_i   = W48;
      step();
      enable_i = 1'b0;
      repeat (3) step();
      #2 rst_i = 1'b1;
      #1 check("rst busy ack", 256'(ack_o), 256'(0));
      step();
      #2 rst_i = 1'b0;
      step();
      check("rst busy mem", dut.memory[48], Q48);
      run_req('{1'b0, 32'h0000_0600, '0, Q48, 48}, "post-rst read");

      // Reset during the ack cycle of a write: ack drops at once and nothing commits
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_0600;
      data_i   = W48;
      step();
      enable_i = 1'b0;
      wait_ack(n);
      check("rst done latency", 256'(n), 256'(LAT));
      #2 rst_i = 1'b1;
      #1 check("rst done ack", 256'(ack_o), 256'(0));
      step();
      #2 rst_i = 1'b0;
      step();
      check("rst done mem", dut.memory[48], Q48);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
